mul_div_unit: RTL and testbench
===============================

// Module: mul_div_unit
// PURPOSE
//  Multi-cycle 16-bit multiply/divide execution unit, directly downstream of the register file.
//  Operands come straight from the register-file read ports (readData1 -> opa, readData2 -> opb).
//  Produces a 2-word result (hi/lo) for write-back; a done pulse tells control to issue the two write-backs.
//  One shift-add / restoring-subtract iteration per clock.
// PARAMETERS
//  WIDTH   16   operand width; results are 2 x WIDTH
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous, active-low reset
//  start      in   1      request; sampled on rising clk edge
//  op         in   1      0 = multiply, 1 = divide
//  op_signed  in   1      signed operation request (honoured only with MULDIV_SIGNED_EN)
//  opa        in   WIDTH  multiplicand / dividend
//  opb        in   WIDTH  multiplier / divisor
//  busy       out  1      iteration in progress
//  done       out  1      one-cycle pulse: results valid
//  result_hi  out  WIDTH  mul: product[2W-1:W]; div: remainder
//  result_lo  out  WIDTH  mul: product[W-1:0];  div: quotient
//  div_by_zero out 1      last divide had opb==0
// BEHAVIOUR
//  - Reset (rst low, async): state IDLE; busy, done, div_by_zero = 0; result_hi, result_lo = 0; counter = 0.
//  - FSM states and transitions:
//    - IDLE -> RUN on start.
//    - RUN: WIDTH iterations, count WIDTH-1 down to 0; RUN -> DONE after the iteration at count 0.
//    - DONE -> IDLE after one cycle. DONE also accepts start, giving back-to-back operation (DONE -> RUN).
//  - Operand capture: opa, opb, op and op_signed are registered on the accepting edge only.
//    Later changes on the inputs have no effect on the operation in flight.
//  - Latency: start accepted at edge E0; done = 1 and results valid after edge E0+WIDTH+1 (17 edges for WIDTH=16).
//  - Outputs in each state:
//    - busy = 1 only in RUN; done = 1 only in DONE.
//    - result_hi/lo and div_by_zero hold their values until the next accepted start.
//  - start is ignored while in RUN. No queuing: a dropped start must be re-issued by control.
//  - Multiply: unsigned 2W-bit product; never overflows.
//  - Divide: restoring division, lo = floor(opa/opb), hi = opa mod opb.
//  - Divide by zero: detected at accept. RUN is skipped (IDLE -> DONE), done one edge after accept.
//    Outputs: lo = all ones, hi = opa, div_by_zero = 1.
//  - div_by_zero is cleared by any accepted non-faulting operation.
//  - rst asserted mid-RUN: operation aborted, all outputs return to reset values, no done pulse.
// CONFIGURATION
//  MULDIV_SIGNED_EN defined:
//    - With op_signed = 1, operands are converted to magnitudes at accept; signs are fixed up entering DONE.
//    - Product sign and quotient sign = sign(opa) XOR sign(opb); remainder takes the dividend's sign.
//    - Overflow case -2^(W-1) / -1: lo = 0x8000, hi = 0x0000, no flag.
//    - Latency is unchanged.
//  MULDIV_SIGNED_EN undefined: op_signed is ignored; all operations are unsigned; no sign logic is synthesised.
// TESTING
//  1. mul opa=0x00FF opb=0x00FF -> done at 17th edge after accept; hi=0x0000 lo=0xFE01; busy high 16 cycles.
//  2. mul 0xFFFF*0xFFFF unsigned -> hi=0xFFFE lo=0x0001.
//  3. div 0x0050/0x0007 -> lo=0x000B hi=0x0003 div_by_zero=0.
//  4. div 0x1234/0x0000 -> done 1 edge after accept; lo=0xFFFF hi=0x1234 div_by_zero=1.
//  5. Signed divide 0xFFF9/0x0002, op_signed=1:
//     - macro on -> lo=0xFFFD hi=0xFFFF; also mul 0xFFFE*0x0003 -> hi=0xFFFF lo=0xFFFA.
//     - macro off -> lo=0x7FFC hi=0x0001.
//  6. start pulsed mid-RUN with new operands -> ignored, first result intact.
//     rst low at RUN cycle 5 -> outputs 0 immediately, no done; next start completes normally.
//     Start held high through DONE -> second op accepted back-to-back.

Source files
------------

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit: shift-add multiply and restoring divide, one iteration per clock.
// Define MULDIV_SIGNED_EN to honour op_signed (sign-magnitude wrapper around the unsigned core).
module mul_div_unit #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             op,
   input  logic             op_signed,
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result_hi,
   output logic [WIDTH-1:0] result_lo,
   output logic             div_by_zero
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

   state_e           state_q;
   logic [CW-1:0]    cnt_q;
   logic             op_q;
   logic [WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;
   logic             busy_q;
   logic             done_q;
   logic             dbz_q;
   logic [WIDTH-1:0] res_hi_q;
   logic [WIDTH-1:0] res_lo_q;

   logic             accept;
   logic             opb_zero;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH-1:0] hi_d;
   logic [WIDTH-1:0] lo_d;
   logic [WIDTH-1:0] fix_hi;
   logic [WIDTH-1:0] fix_lo;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   rem_sh;
   logic             rem_ge;
   logic [WIDTH-1:0] rem_sub;

   // A new operation may be accepted from IDLE or DONE, never while iterating.
   assign accept   = start && (state_q != S_RUN);
   assign opb_zero = op && (opb == '0);

`ifdef MULDIV_SIGNED_EN
   logic neg_a;
   logic neg_b;
   logic neg_a_q;
   logic neg_b_q;

   assign neg_a = op_signed && opa[WIDTH-1];
   assign neg_b = op_signed && opb[WIDTH-1];
   assign a_mag = neg_a ? -opa : opa;
   assign b_mag = neg_b ? -opb : opb;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         neg_a_q <= 1'b0;
         neg_b_q <= 1'b0;
      end else if (accept) begin
         neg_a_q <= neg_a;
         neg_b_q <= neg_b;
      end
   end

   // Product/quotient take sign(a)^sign(b); remainder follows the dividend.
   always_comb begin
      fix_hi = hi_q;
      fix_lo = lo_q;
      if (!dbz_q && (neg_a_q ^ neg_b_q)) begin
         if (op_q) fix_lo = -lo_q;
         else      {fix_hi, fix_lo} = -{hi_q, lo_q};
      end
      if (!dbz_q && op_q && neg_a_q) fix_hi = -hi_q;
   end
`else
   logic unused_op_signed;

   assign unused_op_signed = op_signed;
   assign a_mag  = opa;
   assign b_mag  = opb;
   assign fix_hi = hi_q;
   assign fix_lo = lo_q;
`endif

   // NOTE: every always_comb output gets an unconditional assignment so no latch can be inferred.
   always_comb begin
      sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
      rem_sh  = {hi_q, lo_q[WIDTH-1]};
      rem_ge  = (rem_sh >= {1'b0, mcand_q});
      rem_sub = rem_sh[WIDTH-1:0] - mcand_q;
      if (op_q) begin
         hi_d = rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
         lo_d = {lo_q[WIDTH-2:0], rem_ge};
      end else begin
         hi_d = sum[WIDTH:1];
         lo_d = {sum[0], lo_q[WIDTH-1:1]};
      end
   end

   // Status outputs are registered one cycle behind the state they report.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         op_q     <= 1'b0;
         mcand_q  <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         dbz_q    <= 1'b0;
         res_hi_q <= '0;
         res_lo_q <= '0;
      end else begin
         busy_q <= (state_q == S_RUN);
         done_q <= (state_q == S_DONE);
         if (state_q == S_DONE) begin
            res_hi_q <= fix_hi;
            res_lo_q <= fix_lo;
         end

         unique case (state_q)
            S_RUN: begin
               hi_q <= hi_d;
               lo_q <= lo_d;
               if (cnt_q == '0) state_q <= S_DONE;
               else             cnt_q   <= cnt_q - CW'(1);
            end
            default: state_q <= S_IDLE;
         endcase

         // NOTE: non-blocking assignments let this later accept override the state update above.
         if (accept) begin
            op_q  <= op;
            dbz_q <= opb_zero;
            cnt_q <= CW'(WIDTH - 1);
            if (opb_zero) begin
               hi_q    <= opa;
               lo_q    <= '1;
               state_q <= S_DONE;
            end else begin
               mcand_q <= op ? b_mag : a_mag;
               hi_q    <= '0;
               lo_q    <= op ? a_mag : b_mag;
               state_q <= S_RUN;
            end
         end
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign result_hi   = res_hi_q;
   assign result_lo   = res_lo_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vectors, randomized ops against an arithmetic model,
// start-while-busy, mid-run reset and back-to-back issue.
module tb_mul_div_unit;
   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic         op = 1'b0;
   logic         op_signed = 1'b0;
   logic [W-1:0] opa = '0;
   logic [W-1:0] opb = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] result_hi;
   logic [W-1:0] result_lo;
   logic         div_by_zero;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic         o;
      logic         s;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dz;
      int           lat;
   } vec_t;

   mul_div_unit #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .op          (op),
      .op_signed   (op_signed),
      .opa         (opa),
      .opb         (opb),
      .busy        (busy),
      .done        (done),
      .result_hi   (result_hi),
      .result_lo   (result_lo),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   // Reference: plain integer arithmetic on the operands.
   function automatic void model(input logic o, input logic s, input logic [W-1:0] a,
                                 input logic [W-1:0] b, output logic [W-1:0] hi,
                                 output logic [W-1:0] lo, output logic dz);
      int          sa, sb, p;
      int unsigned ua, ub, up;
      logic        use_signed;
`ifdef MULDIV_SIGNED_EN
      use_signed = s;
`else
      use_signed = 1'b0;
`endif
      dz = 1'b0;
      if (o && b == '0) begin
         hi = a;
         lo = '1;
         dz = 1'b1;
      end else if (use_signed) begin
         sa = $signed(a);
         sb = $signed(b);
         if (!o) begin
            p = sa * sb;
            {hi, lo} = p;
         end else begin
            p  = sa / sb;
            lo = p[W-1:0];
            p  = sa % sb;
            hi = p[W-1:0];
         end
      end else begin
         ua = a;
         ub = b;
         if (!o) begin
            up = ua * ub;
            {hi, lo} = up;
         end else begin
            up = ua / ub;
            lo = up[W-1:0];
            up = ua % ub;
            hi = up[W-1:0];
         end
      end
   endfunction

   // Issue one operation, scramble the inputs after accept, count edges until done (bounded).
   task automatic run_op(input logic o, input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dz,
                         output int lat, output int busy_cnt);
      op = o; op_signed = s; opa = a; opb = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      opa = W'($urandom); opb = W'($urandom); op = 1'($urandom); op_signed = 1'($urandom);
      lat = 0; busy_cnt = 0;
      while (lat < 40) begin
         @(posedge clk); #1;
         lat++;
         if (busy) busy_cnt++;
         if (done) break;
      end
      hi = result_hi; lo = result_lo; dz = div_by_zero;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #12;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
      checks++; if (result_hi !== '0) begin errors++; $display("FAIL reset_hi got %h exp 0000", result_hi); end
      checks++; if (result_lo !== '0) begin errors++; $display("FAIL reset_lo got %h exp 0000", result_lo); end
      checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got %b exp 0", div_by_zero); end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      vec_t         v[$];
      logic [W-1:0] hi, lo;
      logic         dz;
      int           lat, bc;
      v.push_back('{1'b0, 1'b0, 16'h00FF, 16'h00FF, 16'h0000, 16'hFE01, 1'b0, 17});
      v.push_back('{1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0, 17});
      v.push_back('{1'b1, 1'b0, 16'h0050, 16'h0007, 16'h0003, 16'h000B, 1'b0, 17});
      v.push_back('{1'b1, 1'b0, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1'b1, 1});
      v.push_back('{1'b1, 1'b0, 16'h0003, 16'h0050, 16'h0003, 16'h0000, 1'b0, 17});
`ifdef MULDIV_SIGNED_EN
      v.push_back('{1'b1, 1'b1, 16'hFFF9, 16'h0002, 16'hFFFF, 16'hFFFD, 1'b0, 17});
      v.push_back('{1'b0, 1'b1, 16'hFFFE, 16'h0003, 16'hFFFF, 16'hFFFA, 1'b0, 17});
      v.push_back('{1'b1, 1'b1, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0, 17});
      v.push_back('{1'b1, 1'b1, 16'hFFF9, 16'h0000, 16'hFFF9, 16'hFFFF, 1'b1, 1});
`else
      v.push_back('{1'b1, 1'b1, 16'hFFF9, 16'h0002, 16'h0001, 16'h7FFC, 1'b0, 17});
      v.push_back('{1'b1, 1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 17});
`endif
      foreach (v[i]) begin
         run_op(v[i].o, v[i].s, v[i].a, v[i].b, hi, lo, dz, lat, bc);
         checks++; if (lat !== v[i].lat) begin errors++; $display("FAIL dir%0d_latency got %0d exp %0d", i, lat, v[i].lat); end
         checks++; if (bc !== ((v[i].lat == 17) ? 16 : 0)) begin errors++; $display("FAIL dir%0d_busy_cycles got %0d exp %0d", i, bc, (v[i].lat == 17) ? 16 : 0); end
         checks++; if (hi !== v[i].hi) begin errors++; $display("FAIL dir%0d_hi got %h exp %h", i, hi, v[i].hi); end
         checks++; if (lo !== v[i].lo) begin errors++; $display("FAIL dir%0d_lo got %h exp %h", i, lo, v[i].lo); end
         checks++; if (dz !== v[i].dz) begin errors++; $display("FAIL dir%0d_dbz got %b exp %b", i, dz, v[i].dz); end
         @(posedge clk); #1;
         checks++; if (done !== 1'b0) begin errors++; $display("FAIL dir%0d_done_pulse got %b exp 0", i, done); end
         checks++; if (result_lo !== v[i].lo) begin errors++; $display("FAIL dir%0d_hold_lo got %h exp %h", i, result_lo, v[i].lo); end
      end
   endtask

   task automatic test_random();
      logic         o, s;
      logic [W-1:0] a, b, hi, lo, ehi, elo;
      logic         dz, edz;
      int           lat, bc;
      for (int i = 0; i < 60; i++) begin
         o = 1'($urandom);
         s = 1'($urandom);
         a = W'($urandom);
         case ($urandom_range(0, 7))
            0:       b = '0;
            1, 2:    b = W'($urandom_range(1, 15));
            default: b = W'($urandom);
         endcase
         model(o, s, a, b, ehi, elo, edz);
         run_op(o, s, a, b, hi, lo, dz, lat, bc);
         checks++; if (lat !== (edz ? 1 : 17)) begin errors++; $display("FAIL rnd%0d_latency got %0d exp %0d", i, lat, edz ? 1 : 17); end
         checks++; if ({hi, lo, dz} !== {ehi, elo, edz})
            begin errors++; $display("FAIL rnd%0d op=%b s=%b a=%h b=%h got %h_%h dz=%b exp %h_%h dz=%b", i, o, s, a, b, hi, lo, dz, ehi, elo, edz); end
      end
   endtask

   task automatic test_start_ignored();
      logic [W-1:0] ehi, elo;
      logic         edz;
      int           lat;
      bit           extra_done;
      model(1'b0, 1'b0, 16'h1234, 16'h0567, ehi, elo, edz);
      op = 1'b0; op_signed = 1'b0; opa = 16'h1234; opb = 16'h0567; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0;
      repeat (4) begin @(posedge clk); #1; lat++; end
      op = 1'b1; opa = W'($urandom); opb = W'($urandom); start = 1'b1;
      @(posedge clk); #1; lat++;
      start = 1'b0;
      while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
      checks++; if (lat !== 17) begin errors++; $display("FAIL ignore_latency got %0d exp 17", lat); end
      checks++; if ({result_hi, result_lo} !== {ehi, elo}) begin errors++; $display("FAIL ignore_result got %h_%h exp %h_%h", result_hi, result_lo, ehi, elo); end
      extra_done = 1'b0;
      repeat (25) begin @(posedge clk); #1; if (done) extra_done = 1'b1; end
      checks++; if (extra_done !== 1'b0) begin errors++; $display("FAIL ignore_no_queue got %b exp 0", extra_done); end
   endtask

   task automatic test_abort();
      logic [W-1:0] hi, lo, ehi, elo;
      logic         dz, edz;
      int           lat, bc;
      bit           saw_done;
      op = 1'b0; op_signed = 1'b0; opa = 16'hBEEF; opb = 16'h1357; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) begin @(posedge clk); #1; end
      rst = 1'b0;
      #1;
      checks++; if ({busy, done, div_by_zero} !== 3'b000) begin errors++; $display("FAIL abort_flags got %b exp 000", {busy, done, div_by_zero}); end
      checks++; if ({result_hi, result_lo} !== '0) begin errors++; $display("FAIL abort_results got %h_%h exp 0000_0000", result_hi, result_lo); end
      @(posedge clk); #1;
      rst = 1'b1;
      saw_done = 1'b0;
      repeat (25) begin @(posedge clk); #1; if (done) saw_done = 1'b1; end
      checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL abort_no_done got %b exp 0", saw_done); end
      model(1'b1, 1'b0, 16'hBEEF, 16'h0013, ehi, elo, edz);
      run_op(1'b1, 1'b0, 16'hBEEF, 16'h0013, hi, lo, dz, lat, bc);
      checks++; if (lat !== 17) begin errors++; $display("FAIL abort_recover_latency got %0d exp 17", lat); end
      checks++; if ({hi, lo, dz} !== {ehi, elo, edz}) begin errors++; $display("FAIL abort_recover got %h_%h dz=%b exp %h_%h dz=%b", hi, lo, dz, ehi, elo, edz); end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] a1, b1, a2, b2, ehi1, elo1, ehi2, elo2;
      logic         edz1, edz2;
      int           lat;
      a1 = W'($urandom); b1 = W'($urandom);
      a2 = W'($urandom); b2 = W'($urandom_range(1, 200));
      model(1'b0, 1'b0, a1, b1, ehi1, elo1, edz1);
      model(1'b1, 1'b0, a2, b2, ehi2, elo2, edz2);
      op = 1'b0; op_signed = 1'b0; opa = a1; opb = b1; start = 1'b1;
      @(posedge clk); #1;
      op = 1'b1; opa = a2; opb = b2;
      lat = 0;
      while (lat < 40) begin @(posedge clk); #1; lat++; if (done) break; end
      start = 1'b0;
      checks++; if (lat !== 17) begin errors++; $display("FAIL b2b_first_latency got %0d exp 17", lat); end
      checks++; if ({result_hi, result_lo} !== {ehi1, elo1}) begin errors++; $display("FAIL b2b_first got %h_%h exp %h_%h", result_hi, result_lo, ehi1, elo1); end
      lat = 0;
      while (lat < 40) begin @(posedge clk); #1; lat++; if (done) break; end
      checks++; if (lat !== 17) begin errors++; $display("FAIL b2b_second_latency got %0d exp 17", lat); end
      checks++; if ({result_hi, result_lo, div_by_zero} !== {ehi2, elo2, edz2})
         begin errors++; $display("FAIL b2b_second got %h_%h dz=%b exp %h_%h dz=%b", result_hi, result_lo, div_by_zero, ehi2, elo2, edz2); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_start_ignored();
      test_abort();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
